// File: rtl/i2c_slave_ctrl_rw.sv
// I2C slave controller FSM: sequences address/data bytes, ACK/NACK driving and
// rx/tx FIFO handshakes for read and write bursts bounded by MAX_BURST bytes.
module i2c_slave_ctrl_rw #(
  parameter int unsigned MAX_BURST = 16,
  parameter bit          WRITE_EN  = 1'b1,
  localparam int unsigned CNT_W    = $clog2(MAX_BURST + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start_found,
  input  logic             stop_found,
  input  logic             byte_received,
  input  logic             ack_prep,
  input  logic             check_ack,
  input  logic             ack_done,
  input  logic             rw_mode,
  input  logic             address_match,
  input  logic             sda_in,
  input  logic             rx_full,
  input  logic             tx_empty,
  output logic             rx_enable,
  output logic             tx_enable,
  output logic             load_data,
  output logic             read_enable,
  output logic             write_enable,
  output logic [1:0]       sda_mode,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BURST);

  typedef enum logic [3:0] {
    StIdle     = 4'd0,
    StAddr     = 4'd1,
    StAddrWait = 4'd2,
    StNackAddr = 4'd3,
    StPackR    = 4'd4,
    StLoad     = 4'd5,
    StTran     = 4'd6,
    StTranW    = 4'd7,
    StRdAck    = 4'd8,
    StWack     = 4'd9,
    StPackW    = 4'd10,
    StWrx      = 4'd11,
    StWrxWait  = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = (cnt_q == MaxCnt) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we_d    = 1'b0;
    case (state_q)
      StIdle:     if (start_found) state_d = StAddr;
      StAddr:     if (byte_received) state_d = StAddrWait;
      StAddrWait: begin
        if (ack_prep) begin
          if (!address_match)                          state_d = StNackAddr;
          else if (rw_mode && !tx_empty)               state_d = StPackR;
          else if (!rw_mode && WRITE_EN && !rx_full)   state_d = StPackW;
          else                                         state_d = StNackAddr;
        end
      end
      StNackAddr: if (ack_done) state_d = StIdle;
      StPackR:    if (ack_done) state_d = StLoad;
      StLoad:     state_d = StTran;
      StTran:     if (ack_prep) state_d = StTranW;
      StTranW: begin
        if (check_ack) begin
          state_d = StRdAck;
          cnt_d   = cnt_inc;
        end
      end
      StRdAck: begin
        if (!sda_in && (cnt_q < MaxCnt) && !tx_empty) state_d = StWack;
        else                                          state_d = StIdle;
      end
      StWack:     if (ack_done) state_d = StLoad;
      StPackW:    if (ack_done) state_d = StWrx;
      StWrx: begin
        if (byte_received) begin
          state_d = StWrxWait;
          we_d    = 1'b1;
          cnt_d   = cnt_inc;
          // Byte arriving with the count already at the limit is beyond the burst: NACK it.
          ovf_d   = (cnt_q == MaxCnt);
        end
      end
      StWrxWait: begin
        if (ack_prep) state_d = (!ovf_q && !rx_full) ? StPackW : StNackAddr;
      end
      default:    state_d = StIdle;
    endcase

    if (stop_found) begin
      state_d = StIdle;
      we_d    = 1'b0;
    end else if (start_found && state_q != StIdle) begin
      state_d = StAddr;
      we_d    = 1'b0;
    end

    if (state_d == StAddr && state_q != StAddr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_comb begin
    rx_enable   = 1'b0;
    tx_enable   = 1'b0;
    load_data   = 1'b0;
    read_enable = 1'b0;
    sda_mode    = 2'b00;
    case (state_q)
      StAddr, StWrx:     rx_enable = 1'b1;
      StNackAddr:        sda_mode  = 2'b10;
      StPackR, StPackW:  sda_mode  = 2'b01;
      StLoad: begin
        load_data   = 1'b1;
        read_enable = 1'b1;
        sda_mode    = 2'b11;
      end
      StTran: begin
        tx_enable = 1'b1;
        sda_mode  = 2'b11;
      end
      default: ;
    endcase
  end

  assign write_enable = we_q;
  assign byte_count   = cnt_q;
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_i2c_slave_ctrl_rw.sv
// Directed bench for i2c_slave_ctrl_rw: three instances (default, MAX_BURST=2,
// WRITE_EN=0) share one stimulus stream; each check is an immediate assertion.
module tb_i2c_slave_ctrl_rw;

  logic clk = 1'b0;
  logic n_rst, start_found, stop_found, byte_received, ack_prep, check_ack, ack_done;
  logic rw_mode, address_match, sda_in, rx_full, tx_empty;

  logic       a_rx_en, a_tx_en, a_load, a_rd, a_wr, a_busy;
  logic [1:0] a_sda;
  logic [4:0] a_cnt;
  logic       b_rx_en, b_tx_en, b_load, b_rd, b_wr, b_busy;
  logic [1:0] b_sda;
  logic [1:0] b_cnt;
  logic       c_rx_en, c_tx_en, c_load, c_rd, c_wr, c_busy;
  logic [1:0] c_sda;
  logic [4:0] c_cnt;

  int n_pass = 0;
  int n_total = 0;
  int a_ld_cnt = 0;
  int a_wr_cnt = 0;
  int b_wr_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    a_ld_cnt <= a_ld_cnt + int'(a_load);
    a_wr_cnt <= a_wr_cnt + int'(a_wr);
    b_wr_cnt <= b_wr_cnt + int'(b_wr);
  end

  i2c_slave_ctrl_rw #(.MAX_BURST(16), .WRITE_EN(1'b1)) dut_a (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
    .ack_done(ack_done), .rw_mode(rw_mode), .address_match(address_match), .sda_in(sda_in),
    .rx_full(rx_full), .tx_empty(tx_empty), .rx_enable(a_rx_en), .tx_enable(a_tx_en),
    .load_data(a_load), .read_enable(a_rd), .write_enable(a_wr), .sda_mode(a_sda),
    .byte_count(a_cnt), .busy(a_busy)
  );

  i2c_slave_ctrl_rw #(.MAX_BURST(2), .WRITE_EN(1'b1)) dut_b (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
    .ack_done(ack_done), .rw_mode(rw_mode), .address_match(address_match), .sda_in(sda_in),
    .rx_full(rx_full), .tx_empty(tx_empty), .rx_enable(b_rx_en), .tx_enable(b_tx_en),
    .load_data(b_load), .read_enable(b_rd), .write_enable(b_wr), .sda_mode(b_sda),
    .byte_count(b_cnt), .busy(b_busy)
  );

  i2c_slave_ctrl_rw #(.MAX_BURST(16), .WRITE_EN(1'b0)) dut_c (
    .clk(clk), .n_rst(n_rst), .start_found(start_found), .stop_found(stop_found),
    .byte_received(byte_received), .ack_prep(ack_prep), .check_ack(check_ack),
    .ack_done(ack_done), .rw_mode(rw_mode), .address_match(address_match), .sda_in(sda_in),
    .rx_full(rx_full), .tx_empty(tx_empty), .rx_enable(c_rx_en), .tx_enable(c_tx_en),
    .load_data(c_load), .read_enable(c_rd), .write_enable(c_wr), .sda_mode(c_sda),
    .byte_count(c_cnt), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic p_start();   start_found = 1'b1;   tick(); start_found = 1'b0;   endtask
  task automatic p_stop();    stop_found = 1'b1;    tick(); stop_found = 1'b0;    endtask
  task automatic p_byte();    byte_received = 1'b1; tick(); byte_received = 1'b0; endtask
  task automatic p_ackprep(); ack_prep = 1'b1;      tick(); ack_prep = 1'b0;      endtask
  task automatic p_chkack();  check_ack = 1'b1;     tick(); check_ack = 1'b0;     endtask
  task automatic p_ackdone(); ack_done = 1'b1;      tick(); ack_done = 1'b0;      endtask

  task automatic addr(input logic match, input logic rw);
    address_match = match;
    rw_mode = rw;
    p_byte();
    p_ackprep();
  endtask

  int base_a, base_b;

  initial begin
    n_rst = 1'b0;
    {start_found, stop_found, byte_received, ack_prep, check_ack, ack_done} = '0;
    {rw_mode, address_match, sda_in, rx_full, tx_empty} = '0;
    tick(); tick();
    n_rst = 1'b1;
    tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_sda", a_sda, 0);
    chk("rst_cnt", a_cnt, 0);

    // Read burst of 3: master ACK, ACK, NACK.
    base_a = a_ld_cnt;
    p_start();
    chk("rd_addr_rx_en", a_rx_en, 1);
    chk("rd_addr_busy", a_busy, 1);
    addr(1'b1, 1'b1);
    chk("rd_pack_sda", a_sda, 2'b01);
    p_ackdone();
    chk("rd_load", a_load, 1);
    chk("rd_load_pop", a_rd, 1);
    chk("rd_load_sda", a_sda, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) chk("rd_tran_tx_en", a_tx_en, 1);
      p_ackprep();
      chk("rd_tranw_sda", a_sda, 2'b00);
      sda_in = (i == 2);
      p_chkack();
      tick();
      sda_in = 1'b0;
      if (i < 2) p_ackdone();
      if (i == 1) chk("rd_b_limit_idle", b_busy, 0);
    end
    chk("rd_cnt", a_cnt, 3);
    chk("rd_idle", a_busy, 0);
    chk("rd_loads", a_ld_cnt - base_a, 3);
    chk("rd_b_cnt_sat", b_cnt, 2);

    // Write burst of 4; dut_b (MAX_BURST=2) NACKs byte 3; dut_c (read-only) NACKs address.
    base_a = a_wr_cnt;
    base_b = b_wr_cnt;
    p_start();
    addr(1'b1, 1'b0);
    chk("wr_pack_sda", a_sda, 2'b01);
    chk("wr_ro_nack", c_sda, 2'b10);
    p_ackdone();
    chk("wr_ro_idle", c_busy, 0);
    chk("wr_wrx_rx_en", a_rx_en, 1);
    for (int i = 0; i < 4; i++) begin
      p_byte();
      p_ackprep();
      chk($sformatf("wr_ack_sda%0d", i), a_sda, 2'b01);
      if (i < 2) chk($sformatf("wr_b_ack%0d", i), b_sda, 2'b01);
      if (i == 2) chk("wr_b_nack3", b_sda, 2'b10);
      p_ackdone();
      if (i == 2) chk("wr_b_idle", b_busy, 0);
    end
    chk("wr_cnt", a_cnt, 4);
    chk("wr_pushes", a_wr_cnt - base_a, 4);
    chk("wr_b_pushes", b_wr_cnt - base_b, 3);
    chk("wr_b_cnt", b_cnt, 2);
    p_stop();
    chk("wr_stop_idle", a_busy, 0);

    // Address mismatch, then rx FIFO full at ack_prep.
    p_start();
    addr(1'b0, 1'b1);
    chk("mis_nack", a_sda, 2'b10);
    p_ackdone();
    chk("mis_idle", a_busy, 0);
    rx_full = 1'b1;
    p_start();
    addr(1'b1, 1'b0);
    chk("full_nack", a_sda, 2'b10);
    p_ackdone();
    rx_full = 1'b0;
    chk("full_idle", a_busy, 0);

    // Repeated start in WRX, then stop+start together.
    p_start();
    addr(1'b1, 1'b0);
    p_ackdone();
    p_byte();
    p_ackprep();
    p_ackdone();
    chk("rs_cnt_pre", a_cnt, 1);
    p_start();
    chk("rs_cnt_clr", a_cnt, 0);
    chk("rs_addr", a_rx_en, 1);
    start_found = 1'b1;
    stop_found = 1'b1;
    tick();
    start_found = 1'b0;
    stop_found = 1'b0;
    chk("rs_stop_wins", a_busy, 0);

    // Synchronous reset mid-TRAN with pulses present.
    p_start();
    addr(1'b1, 1'b1);
    p_ackdone();
    tick();
    p_ackprep();
    p_chkack();
    tick();
    p_ackdone();
    tick();
    chk("mid_tran_tx_en", a_tx_en, 1);
    chk("mid_tran_cnt", a_cnt, 1);
    n_rst = 1'b0;
    start_found = 1'b1;
    ack_prep = 1'b1;
    byte_received = 1'b1;
    tick();
    start_found = 1'b0;
    ack_prep = 1'b0;
    byte_received = 1'b0;
    chk("rst2_busy", a_busy, 0);
    chk("rst2_sda", a_sda, 0);
    chk("rst2_cnt", a_cnt, 0);
    chk("rst2_outs", {a_rx_en, a_tx_en, a_load, a_rd, a_wr}, 0);
    n_rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
